// File: rtl/chien_pkg.sv
// Shared constants, FSM state type and GF(2^m) helpers for the parallel Chien search.
package chien_pkg;
  localparam int N_MAX     = 1023;
  localparam int T_MAX     = 4;
  localparam int M_MAX     = 10;
  localparam int P         = 4;
  localparam int K_MAX     = (N_MAX + P - 1) / P;
  localparam int CHAIN_MAX = T_MAX * P;
  localparam int BW        = $clog2(K_MAX * P + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  typedef logic [T_MAX:0][M_MAX-1:0] coef_t;

  function automatic logic [M_MAX:0] prim_poly(input logic [3:0] m);
    case (m)
      4'd6:    prim_poly = 11'h043;
      4'd7:    prim_poly = 11'h089;
      4'd8:    prim_poly = 11'h11D;
      4'd9:    prim_poly = 11'h211;
      4'd10:   prim_poly = 11'h409;
      default: prim_poly = '0;
    endcase
  endfunction

  // x * alpha^-k as k chained divide-by-alpha steps; k=0 only masks to m bits.
  function automatic logic [M_MAX-1:0] gf_mul_alpha_inv(input logic [M_MAX-1:0] x,
                                                        input int k,
                                                        input logic [3:0] m);
    logic [M_MAX:0] v;
    logic [M_MAX:0] poly;
    logic [M_MAX:0] mask;
    poly = prim_poly(m);
    mask = (11'd1 << m) - 11'd1;
    v    = {1'b0, x} & mask;
    for (int i = 0; i < CHAIN_MAX; i++) begin
      if (i < k) v = (v[0] ? (v ^ poly) : v) >> 1;
    end
    return v[M_MAX-1:0] & mask[M_MAX-1:0];
  endfunction
endpackage

// File: rtl/chien_search_par_lane.sv
// One evaluation lane: tests sigma at alpha^-(base+LANE) given the running terms r_j.
module chien_lane
  import chien_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [3:0] m,
  input  coef_t      r,
  output logic       hit
);
  logic [M_MAX-1:0] s;

  always_comb begin
    s = '0;
    for (int j = 0; j <= T_MAX; j++) s ^= gf_mul_alpha_inv(r[j], j * LANE, m);
    hit = (s == '0);
  end
endmodule

// File: rtl/chien_search_par.sv
// Parallel Chien search: P positions per cycle, reports error vector, root count and fail.
module chien_search_par
  import chien_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [9:0]                 n,
  input  logic [3:0]                 m,
  input  logic [3:0]                 degree,
  input  logic [(T_MAX+1)*M_MAX-1:0] sigma,
  output logic                       busy,
  output logic                       done,
  output logic [N_MAX-1:0]           err_vec,
  output logic [3:0]                 err_cnt,
  output logic                       fail
);
  state_e           state_q, state_d;
  logic [9:0]       n_q, n_d;
  logic [3:0]       m_q, m_d, deg_q, deg_d;
  logic             valid_q, valid_d;
  logic [BW-1:0]    base_q, base_d;
  coef_t            r_q, r_d;
  logic [N_MAX-1:0] vec_q, vec_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             fail_q, fail_d, busy_q, busy_d, done_q, done_d;

  logic [P-1:0]     hit;
  logic             last, m_ok, n_ok;
  logic [BW-1:0]    pos;
  logic [4:0]       sum;

  assign last = (base_q + BW'(P)) >= BW'(n_q);
  assign m_ok = (m >= 4'd6) && (m <= 4'd10);
  assign n_ok = (n != '0) && ({1'b0, n} <= ((11'd1 << m) - 11'd1));

  for (genvar p = 0; p < P; p++) begin : g_lane
    chien_lane #(.LANE(p)) u_lane (.m(m_q), .r(r_q), .hit(hit[p]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SEARCH;
      ST_SEARCH: if (last)  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    n_d     = n_q;
    m_d     = m_q;
    deg_d   = deg_q;
    valid_d = valid_q;
    base_d  = base_q;
    r_d     = r_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pos     = '0;
    sum     = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d     = n;
          m_d     = m;
          deg_d   = degree;
          valid_d = m_ok && n_ok;
          for (int j = 0; j <= T_MAX; j++)
            r_d[j] = gf_mul_alpha_inv(sigma[j*M_MAX +: M_MAX], 0, m);
          vec_d   = '0;
          cnt_d   = '0;
          fail_d  = 1'b0;
          base_d  = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SEARCH: begin
        sum = {1'b0, cnt_q};
        for (int p = 0; p < P; p++) begin
          pos = base_q + BW'(p);
          if (valid_q && (pos < BW'(n_q)) && hit[p]) begin
            vec_d[pos[9:0]] = 1'b1;
            sum             = sum + 5'd1;
          end
        end
        cnt_d = (sum > 5'd15) ? 4'd15 : sum[3:0];
        for (int j = 0; j <= T_MAX; j++) r_d[j] = gf_mul_alpha_inv(r_q[j], j * P, m_q);
        base_d = base_q + BW'(P);
      end
      ST_FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        // r_0 is never rotated, so it still holds the masked sigma_0
        fail_d = (cnt_q != deg_q) || (deg_q > 4'(T_MAX)) || (r_q[0] == '0) || !valid_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q     <= '0;
      m_q     <= '0;
      deg_q   <= '0;
      valid_q <= 1'b0;
      base_q  <= '0;
      r_q     <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      n_q     <= n_d;
      m_q     <= m_d;
      deg_q   <= deg_d;
      valid_q <= valid_d;
      base_q  <= base_d;
      r_q     <= r_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err_vec = vec_q;
  assign err_cnt = cnt_q;
  assign fail    = fail_q;
endmodule

// File: tb/tb_chien_search_par.sv
// Scoreboard bench for chien_search_par: log/antilog GF model, directed and random runs.
module tb_chien_search_par;
  localparam int NM  = 1023;
  localparam int TM  = 4;
  localparam int MM  = 10;
  localparam int PP  = 4;
  localparam int CLK = 10;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [9:0]              n = '0;
  logic [3:0]              m = '0;
  logic [3:0]              degree = '0;
  logic [(TM+1)*MM-1:0]    sigma = '0;
  logic                    busy, done, fail;
  logic [NM-1:0]           err_vec;
  logic [3:0]              err_cnt;

  chien_search_par dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .m(m), .degree(degree), .sigma(sigma),
    .busy(busy), .done(done), .err_vec(err_vec), .err_cnt(err_cnt), .fail(fail)
  );

  always #(CLK/2) clk = ~clk;

  typedef struct {
    logic [NM-1:0] vec;
    int            cnt;
    bit            fl;
    longint        tdone;
    int            id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   run_id = 0;
  int   gexp[0:1023];
  int   glog[0:1023];

  function automatic int prim(input int mm);
    case (mm)
      6: return 'h43;
      7: return 'h89;
      8: return 'h11d;
      9: return 'h211;
      10: return 'h409;
      default: return 0;
    endcase
  endfunction

  function automatic void build_tables(input int mm);
    int ord;
    int v;
    ord = (1 << mm) - 1;
    v = 1;
    for (int i = 0; i < ord; i++) begin
      gexp[i] = v;
      glog[v] = i;
      v = v << 1;
      if (((v >> mm) & 1) == 1) v = v ^ prim(mm);
    end
  endfunction

  function automatic int gmul(input int a, input int b, input int mm);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % ((1 << mm) - 1)];
  endfunction

  // Reference: evaluate sigma(alpha^-i) by Horner-free power sums over log tables.
  function automatic exp_t model(input int nn, input int mm, input int deg, input int coef[TM+1]);
    exp_t e;
    bit   valid;
    int   ord, x, s, xp, cnt;
    valid = (mm >= 6) && (mm <= 10) && (nn > 0) && (nn <= (1 << mm) - 1);
    e.vec = '0;
    cnt = 0;
    if (valid) begin
      build_tables(mm);
      ord = (1 << mm) - 1;
      for (int i = 0; i < nn; i++) begin
        x = gexp[(ord - i) % ord];
        s = 0;
        xp = 1;
        for (int j = 0; j <= TM; j++) begin
          s = s ^ gmul(coef[j] & ord, xp, mm);
          xp = gmul(xp, x, mm);
        end
        if (s == 0) begin
          e.vec[i] = 1'b1;
          cnt++;
        end
      end
    end
    e.cnt = (cnt > 15) ? 15 : cnt;
    e.fl = !valid || (e.cnt != deg) || (deg > TM) || ((coef[0] & ((1 << mm) - 1)) == 0);
    e.tdone = 0;
    e.id = 0;
    return e;
  endfunction

  task automatic check(input string nm, input longint act, input longint expv, input int id);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL run%0d %s: got %0d, expected %0d", id, nm, act, expv);
    end
  endtask

  task automatic check_vec(input logic [NM-1:0] act, input logic [NM-1:0] expv, input int id);
    int first;
    checks++;
    if (act !== expv) begin
      errors++;
      first = -1;
      for (int i = NM - 1; i >= 0; i--) if (act[i] !== expv[i]) first = i;
      $display("FAIL run%0d err_vec: got %0d bits set, expected %0d bits set (first diff at bit %0d)",
               id, $countones(act), $countones(expv), first);
    end
  endtask

  task automatic issue(input int nn, input int mm, input int deg, input int coef[TM+1]);
    exp_t e;
    int   k;
    e = model(nn, mm, deg, coef);
    run_id++;
    e.id = run_id;
    k = (nn + PP - 1) / PP;
    if (k < 1) k = 1;
    n = 10'(nn);
    m = 4'(mm);
    degree = 4'(deg);
    for (int j = 0; j <= TM; j++) sigma[j*MM +: MM] = 10'(coef[j]);
    start = 1'b1;
    @(posedge clk);
    e.tdone = longint'($time) + longint'((k + 1) * CLK + CLK / 2);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n = 10'($urandom);
    m = 4'($urandom);
    degree = 4'($urandom);
    sigma = 50'({$urandom, $urandom});
    check("busy_after_start", longint'(busy), 1, e.id);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 700 && sb.size() != 0; c++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run5(input int nn, input int mm, input int deg,
                      input int c0, input int c1, input int c2, input int c3, input int c4);
    int c[TM+1];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3; c[4] = c4;
    issue(nn, mm, deg, c);
    wait_idle();
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected 0");
      end else begin
        mon_e = sb.pop_front();
        check_vec(err_vec, mon_e.vec, mon_e.id);
        check("err_cnt", longint'(err_cnt), longint'(mon_e.cnt), mon_e.id);
        check("fail", longint'(fail), longint'(mon_e.fl), mon_e.id);
        check("done_time", longint'($time), mon_e.tdone, mon_e.id);
        check("busy_at_done", longint'(busy), 0, mon_e.id);
      end
    end
  end

  initial begin
    int c[TM+1];
    int sel, mm, nn, ord, lim, npos, deg;
    int pp[TM];
    bit dup;

    #12;
    check("rst_busy", longint'(busy), 0, 0);
    check("rst_done", longint'(done), 0, 0);
    check("rst_vec_zero", longint'(err_vec == '0), 1, 0);
    check("rst_cnt", longint'(err_cnt), 0, 0);
    check("rst_fail", longint'(fail), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run5(63, 6, 1, 1, 'h20, 0, 0, 0);
    run5(63, 6, 2, 1, 'h09, 'h08, 0, 0);
    build_tables(8);
    run5(255, 8, 1, 1, gexp[254], 0, 0, 0);
    run5(63, 6, 2, 1, 'h20, 0, 0, 0);
    run5(31, 5, 1, 1, 'h02, 0, 0, 0);
    run5(63, 6, 0, 0, 0, 0, 0, 0);

    // start during a run is ignored; start in the cycle after done is taken
    c[0] = 1; c[1] = 'h20; c[2] = 0; c[3] = 0; c[4] = 0;
    issue(63, 6, 1, c);
    @(negedge clk);
    @(negedge clk);
    n = 10'd255; m = 4'd8; degree = 4'd2; sigma = 50'({$urandom, $urandom});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    @(negedge clk);
    c[0] = 1; c[1] = 'h09; c[2] = 'h08;
    issue(63, 6, 2, c);
    wait_idle();

    // asynchronous abort mid-search
    c[0] = 1; c[1] = 'h155; c[2] = 'h2a; c[3] = 0; c[4] = 0;
    issue(1023, 10, 2, c);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", longint'(busy), 0, run_id);
    check("abort_done", longint'(done), 0, run_id);
    check("abort_vec_zero", longint'(err_vec == '0), 1, run_id);
    check("abort_cnt", longint'(err_cnt), 0, run_id);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    run5(63, 6, 1, 1, 'h20, 0, 0, 0);

    for (int r = 0; r < 30; r++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        mm = $urandom_range(0, 15);
        nn = $urandom_range(1, 1023);
        for (int j = 0; j <= TM; j++) c[j] = $urandom_range(0, 1023);
        deg = $urandom_range(0, 7);
      end else begin
        mm = $urandom_range(6, 10);
        ord = (1 << mm) - 1;
        nn = (sel == 1) ? $urandom_range(1, 1023) : $urandom_range(1, ord);
        if (sel == 2) begin
          for (int j = 0; j <= TM; j++) c[j] = $urandom_range(0, 1023);
          deg = $urandom_range(0, 5);
        end else begin
          lim = (nn < ord) ? nn : ord;
          npos = $urandom_range(0, (lim < TM) ? lim : TM);
          for (int i = 0; i < npos; i++) begin
            do begin
              pp[i] = $urandom_range(0, lim - 1);
              dup = 1'b0;
              for (int k2 = 0; k2 < i; k2++) if (pp[k2] == pp[i]) dup = 1'b1;
            end while (dup);
          end
          build_tables(mm);
          c[0] = 1; c[1] = 0; c[2] = 0; c[3] = 0; c[4] = 0;
          for (int i = 0; i < npos; i++)
            for (int j = TM; j >= 1; j--) c[j] = c[j] ^ gmul(gexp[pp[i]], c[j-1], mm);
          deg = (sel == 3) ? npos + 1 : npos;
        end
      end
      issue(nn, mm, deg, c);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
